hex_bcd_counter: RTL
====================

HEX_BCD_COUNTER -- requirements
Module: hex_bcd_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 2, giving the number of BCD digits and seven-segment displays (range 1-6).
REQ-002 The block SHALL have parameter TICK_DIV, default 50_000_000, giving the number of clock cycles per count step (range 1 to 2^26).
REQ-003 The block SHALL have parameter BLANK_LZ, default 1, where 1 blanks leading zero digits and 0 shows all digits.
REQ-004 MAX10_CLK1_50  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 RESET_N  in  1  SHALL be a synchronous, active-low reset.
REQ-006 en  in  1  SHALL be the count enable; it also gates the prescaler.
REQ-007 up_dn  in  1  SHALL select direction: 1 counts up, 0 counts down.
REQ-008 load  in  1  SHALL be a single-cycle load strobe.
REQ-009 load_val  in  4*NUM_DIGITS  SHALL carry the BCD load value, with digit i at bits 4i+3:4i.
REQ-010 count_bcd  out  4*NUM_DIGITS  SHALL be the registered BCD count.
REQ-011 HEX  out  8*NUM_DIGITS  SHALL carry the active-low segments, digit i at bits 8i+7:8i, with bit0-6 = segments a-g and bit7 = dp.
REQ-012 wrap  out  1  SHALL be a one-cycle pulse on wrap-around.
REQ-013 load_err  out  1  SHALL be a sticky flag that is set when a load is rejected.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while en=1, hold while en=0, and raise the internal step on the cycle it equals TICK_DIV-1; it then returns to 0.
REQ-015 On step, count SHALL add or subtract 1 in BCD, with decimal carry/borrow across all digits; each digit SHALL remain 0-9 at all times.
REQ-016 Up from all-9s SHALL give all-0s with wrap=1 for one cycle; down from all-0s SHALL give all-9s with wrap=1 for one cycle.
REQ-017 The count SHALL update on the clock edge following the cycle in which step is raised; wrap SHALL assert in the same cycle as the wrapped count.
REQ-018 load=1 SHALL take priority over step: if every load_val nibble is <=9, count takes load_val on the next edge, the prescaler clears to 0, and wrap stays 0.
REQ-019 load=1 with any nibble >9 SHALL leave count and prescaler unchanged and set load_err.
REQ-020 load_err SHALL clear only on reset or on a valid load.
REQ-021 HEX SHALL be decoded combinationally from count_bcd with zero added latency.
REQ-022 Encodings SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off), and blank=FF.
REQ-023 With BLANK_LZ=1, digit i>0 SHALL be blank when it and all more-significant digits are 0; digit 0 SHALL never be blanked.
REQ-024 A change of up_dn SHALL take effect on the next step without resetting the prescaler.

Reset
REQ-025 While RESET_N=0 at a clock edge, the block SHALL set count_bcd=0, prescaler=0, wrap=0, and load_err=0.
REQ-026 Reset SHALL override load and step in the same cycle.
REQ-027 Reset asserted mid-count SHALL take effect on the next edge, with no partial carry retained.
REQ-028 After reset, HEX SHALL show C0 on digit 0 and FF on the other digits (BLANK_LZ=1), or C0 on all digits (BLANK_LZ=0).

Verification (NUM_DIGITS=2, TICK_DIV=4, BLANK_LZ=1)
REQ-029 Reset, then en=1, up_dn=1 for 40 cycles -> count steps every 4 cycles to 0x10; HEX = {F9,C0}.
REQ-030 load_val=0x99, load, then up_dn=1 for one step -> count=0x00, wrap pulses for exactly 1 cycle, HEX = {FF,C0}.
REQ-031 Count=0x00, up_dn=0, one step -> count=0x99, wrap=1 for 1 cycle, HEX = {90,90}.
REQ-032 load_val=0x3A with load -> count unchanged, load_err=1; then load_val=0x42 with load -> count=0x42, load_err=0.
REQ-033 load and step in the same cycle with load_val=0x05 -> count=0x05, prescaler=0, wrap=0.
REQ-034 en=0 for 10 cycles mid-prescale, then en=1 -> step occurs after the remaining prescaler cycles only; RESET_N=0 coincident with a step -> count=0x00.

Source files
------------

// File: rtl/hex_bcd_counter_if.sv
// Control and display bus of the hex_bcd_counter; the slave modport is the counter side.
// master drives the count controls and load word, and observes the count, segments and flags.
interface hex_bcd_counter_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    en;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic [8*NUM_DIGITS-1:0] HEX;
  logic                    wrap;
  logic                    load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count_bcd, HEX, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count_bcd, HEX, wrap, load_err
  );
endinterface

// File: rtl/hex_bcd_counter.sv
// Prescaled up/down BCD counter with validated load and 7-segment decode; count moves one edge
// after the prescaler's last cycle, HEX is combinational from the count; no backpressure (en only gates).
module hex_bcd_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 50_000_000,
  parameter int BLANK_LZ   = 1
) (
  input logic              MAX10_CLK1_50,
  input logic              RESET_N,
  hex_bcd_counter_if.slave bus
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]           r_presc;
  logic [4*NUM_DIGITS-1:0] r_count;
  logic                    r_wrap;
  logic                    r_load_err;

  logic                    w_step;
  logic                    w_load_ok;
  logic                    w_carry;
  logic [4*NUM_DIGITS-1:0] w_next;
  logic [8*NUM_DIGITS-1:0] w_hex;
  logic                    w_lz;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign w_step = bus.en && (r_presc == PRESC_LAST);

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) w_load_ok = 1'b0;
    end
  end

  // Ripple the decimal carry/borrow; a carry out of the top digit is the wrap.
  always_comb begin
    w_next  = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (bus.up_dn) begin
          if (r_count[4*i +: 4] == 4'd9) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (r_count[4*i +: 4] == 4'd0) begin
            w_next[4*i +: 4] = 4'd9;
          end else begin
            w_next[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      r_presc    <= '0;
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.load) begin
        // A rejected load freezes count and prescaler for that cycle.
        if (w_load_ok) begin
          r_count    <= bus.load_val;
          r_presc    <= '0;
          r_load_err <= 1'b0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (bus.en) begin
        if (w_step) begin
          r_presc <= '0;
          r_count <= w_next;
          r_wrap  <= w_carry;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  // Scan from the top digit; a digit is a leading zero while everything above it is zero too.
  always_comb begin
    w_hex = '0;
    w_lz  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_lz = w_lz && (r_count[4*i +: 4] == 4'd0);
      if ((i > 0) && (BLANK_LZ != 0) && w_lz) begin
        w_hex[8*i +: 8] = 8'hFF;
      end else begin
        w_hex[8*i +: 8] = seg7(r_count[4*i +: 4]);
      end
    end
  end

  assign bus.count_bcd = r_count;
  assign bus.HEX       = w_hex;
  assign bus.wrap      = r_wrap;
  assign bus.load_err  = r_load_err;

endmodule
